// File: rtl/tx_scheduler.sv
// Audio sample buffer and byte scheduler for a pulse-width transmitter.
// Optional packet framing (header/trailer bytes) enabled by defining TX_SCHED_FRAMING_EN.
module tx_scheduler #(
  parameter int         FIFO_DEPTH   = 16,
  parameter int         PACKET_LEN   = 32,
  parameter logic [7:0] HEADER_BYTE  = 8'hA5,
  parameter logic [7:0] TRAILER_BYTE = 8'h5A
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          record_start,
  input  logic                          record_done,
  input  logic [7:0]                    audio_in,
  input  logic                          audio_valid_in,
  input  logic                          tx_busy_in,
  output logic [7:0]                    tx_data_out,
  output logic                          tx_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          overflow_out,
  output logic                          active_out,
  output logic [2:0]                    state_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    STREAM  = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    TRAILER = 3'd5
  } state_t;

  state_t           state_q, state_d;
  state_t           ret_q, ret_d;
  logic             pend_q, pend_d;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             fifo_empty, fifo_full;
  logic             push, pop, drop, issue;
  logic [7:0]       issue_byte;

`ifdef TX_SCHED_FRAMING_EN
  localparam int PKT_W = $clog2(PACKET_LEN + 1);
  logic [PKT_W-1:0] pkt_q, pkt_d;
`endif

  assign fifo_empty     = (count_q == '0);
  assign fifo_full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign active_out     = (state_q != IDLE);
  assign fifo_count_out = count_q;
  assign overflow_out   = overflow_q;
  assign state_out      = state_q;

  // A full FIFO still accepts a sample when the head is popped in the same cycle.
  assign push = active_out && audio_valid_in && (!fifo_full || pop);
  assign drop = active_out && audio_valid_in && fifo_full && !pop;

  // Transmitter handshake: tx_valid_out is a one-cycle issue strobe with tx_data_out valid
  // alongside it; no new issue happens until tx_busy_in has been seen high and then low again.
  assign issue_byte = (state_q == HEADER)  ? HEADER_BYTE  :
                      (state_q == TRAILER) ? TRAILER_BYTE : mem[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    pend_d  = pend_q;
    pop     = 1'b0;
    issue   = 1'b0;
`ifdef TX_SCHED_FRAMING_EN
    pkt_d   = pkt_q;
`endif
    if (record_done && state_q != IDLE) pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (record_start) begin
          pend_d = record_done;
`ifdef TX_SCHED_FRAMING_EN
          pkt_d   = '0;
          state_d = HEADER;
`else
          state_d = STREAM;
`endif
        end
      end
`ifdef TX_SCHED_FRAMING_EN
      HEADER: begin
        // An ending session with nothing left to send skips straight to the trailer.
        if (pend_q && fifo_empty) begin
          state_d = TRAILER;
        end else if (!tx_busy_in) begin
          issue   = 1'b1;
          ret_d   = STREAM;
          state_d = WAIT_HI;
        end
      end
`endif
      STREAM: begin
        if (!fifo_empty && !tx_busy_in) begin
          pop     = 1'b1;
          issue   = 1'b1;
          state_d = WAIT_HI;
`ifdef TX_SCHED_FRAMING_EN
          if (pkt_q == PKT_W'(PACKET_LEN - 1)) begin
            pkt_d = '0;
            ret_d = HEADER;
          end else begin
            pkt_d = pkt_q + PKT_W'(1);
            ret_d = STREAM;
          end
`else
          ret_d   = STREAM;
`endif
        end else if (pend_q && fifo_empty) begin
`ifdef TX_SCHED_FRAMING_EN
          state_d = TRAILER;
`else
          state_d = IDLE;
          pend_d  = 1'b0;
`endif
        end
      end
      WAIT_HI: begin
        if (tx_busy_in) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy_in) begin
          state_d = ret_q;
          if (ret_q == IDLE) pend_d = 1'b0;
        end
      end
`ifdef TX_SCHED_FRAMING_EN
      TRAILER: begin
        if (!tx_busy_in) begin
          issue   = 1'b1;
          ret_d   = IDLE;
          state_d = WAIT_HI;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      ret_q        <= STREAM;
      pend_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      tx_valid_out <= 1'b0;
      tx_data_out  <= 8'h00;
`ifdef TX_SCHED_FRAMING_EN
      pkt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      pend_q       <= pend_d;
      tx_valid_out <= issue;
      if (issue) tx_data_out <= issue_byte;
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      if (state_q == IDLE && record_start) overflow_q <= 1'b0;
      else if (drop)                       overflow_q <= 1'b1;
`ifdef TX_SCHED_FRAMING_EN
      pkt_q        <= pkt_d;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr_q] <= audio_in;
  end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, sample buffer entries (power of two, >=4).
REQ-002 Parameter PACKET_LEN, default 32, samples per framed packet (>=1).
REQ-003 Parameter HEADER_BYTE, default 8'hA5, byte issued before each packet.
REQ-004 Parameter TRAILER_BYTE, default 8'h5A, byte issued after the last sample of a recording.
REQ-005 clk_in  input  1  system clock (98.3 MHz); the block uses only this one clock.
REQ-006 rst_in  input  1  reset, synchronous and active-high.
REQ-007 record_start  input  1  one-cycle pulse that begins a recording session.
REQ-008 record_done  input  1  one-cycle pulse that ends the session.
REQ-009 audio_in  input  8  audio sample, sampled when audio_valid_in=1.
REQ-010 audio_valid_in  input  1  one-cycle strobe at about 12 kHz.
REQ-011 tx_busy_in  input  1  pulse-width transmitter valid_out; high while a byte is on air.
REQ-012 tx_data_out  output  8  byte handed to the transmitter.
REQ-013 tx_valid_out  output  1  one-cycle issue strobe to the transmitter's audio_valid_in.
REQ-014 fifo_count_out  output  $clog2(FIFO_DEPTH)+1  current buffer occupancy.
REQ-015 overflow_out  output  1  sticky flag: at least one sample was dropped.
REQ-016 active_out  output  1  high from record_start until the trailer (or final sample) completes.

Function
REQ-017 A sample is pushed into the FIFO on audio_valid_in when active_out=1 and the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-018 A sample that arrives while the FIFO is full with no pop in that cycle is dropped, and overflow_out is set in the next cycle.
REQ-019 audio_valid_in is ignored when active_out=0, and the FIFO is left unchanged.
REQ-020 States: IDLE, HEADER, STREAM, WAIT_HI, WAIT_LO, TRAILER.
REQ-021 IDLE: on record_start, go to HEADER, set active_out=1, clear the packet counter, and clear overflow_out.
REQ-022 HEADER: issue HEADER_BYTE when tx_busy_in=0, then go to WAIT_HI with return target STREAM.
REQ-023 STREAM: if the FIFO is non-empty and tx_busy_in=0, pop the head, issue it, increment the packet counter, and go to WAIT_HI.
REQ-024 The packet counter reaching PACKET_LEN after an issue sets the return target to HEADER and resets the counter to 0; otherwise the return target is STREAM.
REQ-025 WAIT_HI: wait until tx_busy_in=1, then go to WAIT_LO; wait until tx_busy_in=0, then go to the return target.
REQ-026 No second issue occurs while the transmitter is busy or before its busy rise has been seen.
REQ-027 Each issue drives tx_valid_out=1 for exactly one cycle, with tx_data_out valid in that same cycle.
REQ-028 tx_data_out holds its last value otherwise.
REQ-029 Latency from sample push into an empty FIFO, in STREAM with the transmitter idle, to tx_valid_out is 2 cycles.
REQ-030 record_done latches a pending-end flag. When the flag is set, the FIFO is empty, and the state is STREAM or HEADER, go to TRAILER.
REQ-031 TRAILER: issue TRAILER_BYTE, wait for the busy high then low, then go to IDLE, clear active_out and clear pending-end.
REQ-032 The header is suppressed if the FIFO is empty when the pending-end flag is set.
REQ-033 record_start while active_out=1 is ignored.
REQ-034 record_done while in IDLE is ignored.
REQ-035 record_start and record_done in the same cycle in IDLE: start the session, with pending-end set.
REQ-036 Occupancy arithmetic wraps its read and write pointers modulo FIFO_DEPTH.
REQ-037 fifo_count_out saturates at neither bound; it never exceeds FIFO_DEPTH.

Reset
REQ-038 rst_in=1 at a clock edge forces IDLE, empties the FIFO, and clears the packet counter and pending-end flag.
REQ-039 rst_in=1 at a clock edge sets tx_valid_out=0, tx_data_out=0, overflow_out=0, active_out=0 and fifo_count_out=0.
REQ-040 Reset takes priority over every other input, including a reset applied mid-wait with tx_busy_in=1.
REQ-041 A byte already handed to the transmitter is not re-issued after reset.

Configuration
REQ-042 Macro TX_SCHED_FRAMING_EN defined: header and trailer behaviour exactly as in REQ-020 to REQ-035.
REQ-043 Macro TX_SCHED_FRAMING_EN undefined: HEADER and TRAILER are never entered; record_start goes directly to STREAM.
REQ-044 Macro TX_SCHED_FRAMING_EN undefined: pending-end with an empty FIFO returns directly to IDLE, and the packet counter is absent.

Verification
REQ-045 Start a session, push 3 samples 01,02,03, with a transmitter model holding busy 1000 cycles after each strobe -> issues A5,01,02,03, each strobe only after the previous busy fall.
REQ-046 PACKET_LEN=2, push 4 samples 10,11,12,13 -> issues A5,10,11,A5,12,13.
REQ-047 Hold tx_busy_in=1, push 17 samples with FIFO_DEPTH=16 -> fifo_count_out=16 and overflow_out=1, and the 17th sample is never issued.
REQ-048 Push 2 samples, then pulse record_done -> both samples, then 5A, are issued; active_out falls after the busy fall of 5A, and the state is IDLE.
REQ-049 Assert rst_in while in WAIT_LO with 5 samples buffered -> all outputs 0 next cycle; a new record_start issues A5 with no stale sample.
REQ-050 Build without TX_SCHED_FRAMING_EN, push 01,02, then record_done -> issues exactly 01,02, with no A5 or 5A.
